// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port request/ack arbiter and sequencer in front of the single-port data memory
// Port 0 is the MEM stage, port 1 the loader/debug port; one DM access is in flight at a time.
module dm_arbiter #(
   parameter int N          = 7,
   parameter int RD_LAT     = 1,
   parameter int FIXED_PRIO = 0
) (
   input  logic          clka,
   input  logic          rst,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [N-1:0]  p0_addr,
   input  logic [31:0]   p0_wdata,
   output logic          p0_ack,
   output logic [31:0]   p0_rdata,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [N-1:0]  p1_addr,
   input  logic [31:0]   p1_wdata,
   output logic          p1_ack,
   output logic [31:0]   p1_rdata,
   output logic          mem_ena,
   output logic          mem_wea,
   output logic [N-1:0]  mem_addra,
   output logic [31:0]   mem_dina,
   input  logic [31:0]   mem_douta,
   output logic          busy,
   output logic          grant_id
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

   localparam logic [2:0] LP_WAIT_INIT = 3'(RD_LAT - 1);

   state_t        r_state;
   state_t        w_next;
   logic          r_we;
   logic          r_grant;
   logic          r_last;
   logic [N-1:0]  r_addr;
   logic [31:0]   r_wdata;
   logic [31:0]   r_p0_rdata;
   logic [31:0]   r_p1_rdata;
   logic [2:0]    r_cnt;
   logic          w_pick1;
   logic          w_rd_ack;

   // On a tie the port that did not own the last completed transaction wins.
   assign w_pick1 = p1_req & (~p0_req | ((FIXED_PRIO == 0) & ~r_last));

   always_ff @(posedge clka) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      mem_ena = 1'b0;
      mem_wea = 1'b0;
      p0_ack  = 1'b0;
      p1_ack  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (p0_req | p1_req) begin
               w_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            mem_ena = 1'b1;
            mem_wea = r_we;
            if (r_we || RD_LAT <= 1) begin
               w_next = S_ACK;
            end else begin
               w_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_cnt <= 3'd1) begin
               w_next = S_ACK;
            end
         end
         S_ACK: begin
            p0_ack = ~r_grant;
            p1_ack = r_grant;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Read data is forwarded straight from DM in the ack cycle, then held in the port register.
   assign w_rd_ack  = (r_state == S_ACK) & ~r_we;
   assign p0_rdata  = (w_rd_ack & ~r_grant) ? mem_douta : r_p0_rdata;
   assign p1_rdata  = (w_rd_ack &  r_grant) ? mem_douta : r_p1_rdata;
   assign mem_addra = r_addr;
   assign mem_dina  = r_wdata;
   assign busy      = (r_state != S_IDLE);
   assign grant_id  = r_grant;

   always_ff @(posedge clka) begin
      if (rst) begin
         r_we       <= 1'b0;
         r_grant    <= 1'b0;
         r_last     <= 1'b1;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_p0_rdata <= '0;
         r_p1_rdata <= '0;
         r_cnt      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (p0_req | p1_req) begin
                  r_grant <= w_pick1;
                  r_we    <= w_pick1 ? p1_we    : p0_we;
                  r_addr  <= w_pick1 ? p1_addr  : p0_addr;
                  r_wdata <= w_pick1 ? p1_wdata : p0_wdata;
               end
            end
            S_ISSUE: begin
               r_cnt <= LP_WAIT_INIT;
            end
            S_WAIT: begin
               r_cnt <= r_cnt - 3'd1;
            end
            S_ACK: begin
               r_last <= r_grant;
               if (!r_we) begin
                  if (r_grant) begin
                     r_p1_rdata <= mem_douta;
                  end else begin
                     r_p0_rdata <= mem_douta;
                  end
               end
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

endmodule
